// File: rtl/cpu7_ifu_pcgen.sv
// Fetch-address stage: owns pc_f, issues icache line requests, applies redirects.
// Optional perf counters are enabled with `define CPU7_IFU_PCGEN_PERF_EN.
module cpu7_ifu_pcgen #(
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] pc_f,
    output logic        ifu_icu_req_ic1,
    output logic [31:0] ifu_icu_addr_ic1,
    input  logic        icu_ifu_ack_ic1,
    input  logic        icu_ifu_data_valid_ic2,
    input  logic        inst_valid_f,
    input  logic        fetch_ahead,
    input  logic        exu_ifu_stall_req,
    input  logic        exu_ifu_br_taken,
    input  logic [31:0] exu_ifu_br_target,
    output logic        flush_iq,
    output logic        ifu_busy
`ifdef CPU7_IFU_PCGEN_PERF_EN
    ,
    output logic [31:0] perf_fetch_stall_cnt,
    output logic [15:0] perf_redirect_drop_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DROP
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic        need_q, need_d;

    logic        br;
    logic        ack;
    logic        dv;
    logic [31:0] tgt_line;
    logic [31:0] cur_line;
    logic [31:0] next_line;

    assign br        = exu_ifu_br_taken;
    assign ack       = icu_ifu_ack_ic1;
    assign dv        = icu_ifu_data_valid_ic2;
    assign tgt_line  = {exu_ifu_br_target[31:3], 3'b000};
    assign cur_line  = {pc_q[31:3], 3'b000};
    assign next_line = {pc_q[31:3] + 29'd1, 3'b000};

    // In DROP, addr_q already holds the redirect line awaiting issue.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        need_d  = need_q;
        unique case (state_q)
            IDLE: begin
                if (br) begin
                    state_d = REQ;
                    addr_d  = tgt_line;
                    need_d  = 1'b0;
                end else if (need_q) begin
                    state_d = REQ;
                    addr_d  = cur_line;
                    need_d  = 1'b0;
                end else if (fetch_ahead && next_line != addr_q) begin
                    state_d = REQ;
                    addr_d  = next_line;
                end
            end
            REQ: begin
                if (br) begin
                    state_d = (ack && !dv) ? DROP : REQ;
                    addr_d  = tgt_line;
                end else if (ack) begin
                    state_d = dv ? IDLE : WAIT;
                end
            end
            WAIT: begin
                if (br) begin
                    state_d = dv ? REQ : DROP;
                    addr_d  = tgt_line;
                end else if (dv) begin
                    state_d = IDLE;
                end
            end
            DROP: begin
                if (br) begin
                    addr_d = tgt_line;
                end
                if (dv) begin
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pc_d = pc_q;
        if (br) begin
            pc_d = exu_ifu_br_target;
        end else if (inst_valid_f && !exu_ifu_stall_req) begin
            pc_d = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= {RESET_PC[31:3], 3'b000};
            need_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            need_q  <= need_d;
        end
    end

    assign pc_f             = pc_q;
    assign ifu_icu_req_ic1  = (state_q == REQ);
    assign ifu_icu_addr_ic1 = addr_q;
    assign ifu_busy         = (state_q != IDLE);
    assign flush_iq         = br || (state_q == DROP && dv);

`ifdef CPU7_IFU_PCGEN_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [15:0] drop_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= 32'd0;
            drop_cnt_q  <= 16'd0;
        end else begin
            if ((state_q == REQ || state_q == WAIT) && !inst_valid_f) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (state_d == DROP && state_q != DROP) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
        end
    end

    assign perf_fetch_stall_cnt   = stall_cnt_q;
    assign perf_redirect_drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_cpu7_ifu_pcgen.sv
// Directed bench for cpu7_ifu_pcgen: request addresses and flush pulses
// go through scoreboard queues checked by a negedge monitor.
module tb_cpu7_ifu_pcgen;

    localparam logic [31:0] RST_PC = 32'h1c000000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_f;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic        dv;
    logic        iv;
    logic        fa;
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic        flush;
    logic        busy;
`ifdef CPU7_IFU_PCGEN_PERF_EN
    logic [31:0] perf_stall;
    logic [15:0] perf_drop;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_req_q[$];
    logic [31:0] exp_flush_q[$];

    cpu7_ifu_pcgen #(.RESET_PC(RST_PC)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .pc_f                   (pc_f),
        .ifu_icu_req_ic1        (req),
        .ifu_icu_addr_ic1       (addr),
        .icu_ifu_ack_ic1        (ack),
        .icu_ifu_data_valid_ic2 (dv),
        .inst_valid_f           (iv),
        .fetch_ahead            (fa),
        .exu_ifu_stall_req      (stall),
        .exu_ifu_br_taken       (br),
        .exu_ifu_br_target      (tgt),
        .flush_iq               (flush),
        .ifu_busy               (busy)
`ifdef CPU7_IFU_PCGEN_PERF_EN
        ,
        .perf_fetch_stall_cnt   (perf_stall),
        .perf_redirect_drop_cnt (perf_drop)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Monitor: each accepted request and each flush pulse consumes one entry.
    always @(negedge clk) begin
        if (!reset) begin
            if (req && ack) begin
                if (exp_req_q.size() == 0) begin
                    chk("unexpected_req", addr, 32'hdeadbeef);
                end else begin
                    chk("req_addr", addr, exp_req_q.pop_front());
                end
            end
            if (flush) begin
                if (exp_flush_q.size() == 0) begin
                    chk("unexpected_flush", pc_f, 32'hdeadbeef);
                end else begin
                    chk("flush_pc", pc_f, exp_flush_q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req();
        for (int i = 0; i < 20 && !req; i++) tick();
        chk("req_seen", {31'd0, req}, 32'd1);
    endtask

    task automatic ack_cycle(input logic with_dv);
        ack = 1'b1;
        dv  = with_dv;
        tick();
        ack = 1'b0;
        dv  = 1'b0;
    endtask

    task automatic dv_cycle();
        dv = 1'b1;
        tick();
        dv = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        ack = 0; dv = 0; iv = 0; fa = 0; stall = 0; br = 0;
        tgt = 32'd0;
        repeat (3) tick();
        chk("rst_pc", pc_f, RST_PC);
        chk("rst_req", {31'd0, req}, 32'd0);
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);

        // 1: reset exit, ack after 1 cycle, data 2 cycles after ack
        exp_req_q.push_back(32'h1c000000);
        reset = 1'b0;
        tick();
        chk("s1_addr0", addr, 32'h1c000000);
        wait_req();
        tick();
        ack_cycle(1'b0);
        tick();
        dv_cycle();
        chk("s1_idle", {31'd0, busy}, 32'd0);
        exp_req_q.push_back(32'h1c000008);
        iv = 1; fa = 1;
        tick();
        iv = 0; fa = 0;
        chk("s1_pc4", pc_f, 32'h1c000004);
        chk("s1_ahead", addr, 32'h1c000008);
        ack_cycle(1'b0);
        dv_cycle();

        // 2: redirect while WAIT
        iv = 1;
        tick();
        iv = 0;
        chk("s2_pc8", pc_f, 32'h1c000008);
        exp_req_q.push_back(32'h1c000010);
        fa = 1;
        tick();
        fa = 0;
        wait_req();
        ack_cycle(1'b0);
        exp_flush_q.push_back(32'h1c000008);
        br = 1; tgt = 32'h1c000104;
        tick();
        br = 0;
        chk("s2_pc_tgt", pc_f, 32'h1c000104);
        chk("s2_drop_noreq", {31'd0, req}, 32'd0);
        chk("s2_busy", {31'd0, busy}, 32'd1);
        exp_flush_q.push_back(32'h1c000104);
        exp_req_q.push_back(32'h1c000100);
        dv_cycle();
        wait_req();
        ack_cycle(1'b1);
`ifdef CPU7_IFU_PCGEN_PERF_EN
        chk("s2_perf_drop", {16'd0, perf_drop}, 32'd1);
`endif

        // 3: redirect while REQ unacked
        fa = 1;
        tick();
        fa = 0;
        chk("s3_req_old", addr, 32'h1c000108);
        exp_flush_q.push_back(32'h1c000104);
        exp_req_q.push_back(32'h1c000020);
        br = 1; tgt = 32'h1c000020;
        tick();
        br = 0;
        chk("s3_req_new", addr, 32'h1c000020);
        chk("s3_still_req", {31'd0, req}, 32'd1);
`ifdef CPU7_IFU_PCGEN_PERF_EN
        chk("s3_perf_drop", {16'd0, perf_drop}, 32'd1);
`endif
        ack_cycle(1'b0);
        dv_cycle();
        chk("s3_pc", pc_f, 32'h1c000020);

        // 4: stall holds pc, then advance
        stall = 1; iv = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("s4_stall_pc", pc_f, 32'h1c000020);
        end
        stall = 0;
        tick();
        chk("s4_pc1", pc_f, 32'h1c000024);
        tick();
        chk("s4_pc2", pc_f, 32'h1c000028);
        iv = 0;
        chk("s4_noreq", {31'd0, req}, 32'd0);

        // 5: ack+data with redirect in the same cycle
        exp_req_q.push_back(32'h1c000030);
        fa = 1;
        tick();
        fa = 0;
        exp_flush_q.push_back(32'h1c000028);
        exp_req_q.push_back(32'h1c000200);
        br = 1; tgt = 32'h1c000200;
        ack = 1; dv = 1;
        tick();
        br = 0; ack = 0; dv = 0;
        chk("s5_req", {31'd0, req}, 32'd1);
        chk("s5_addr", addr, 32'h1c000200);
        chk("s5_pc", pc_f, 32'h1c000200);
`ifdef CPU7_IFU_PCGEN_PERF_EN
        chk("s5_perf_drop", {16'd0, perf_drop}, 32'd1);
`endif
        ack_cycle(1'b1);

        // 6: fetch-ahead wraps past 0xfffffff8
        exp_flush_q.push_back(32'h1c000200);
        exp_req_q.push_back(32'hfffffff8);
        br = 1; tgt = 32'hfffffff8;
        tick();
        br = 0;
        ack_cycle(1'b1);
        iv = 1;
        tick();
        iv = 0;
        chk("s6_pc", pc_f, 32'hfffffffc);
        exp_req_q.push_back(32'h00000000);
        fa = 1;
        tick();
        fa = 0;
        ack_cycle(1'b1);

        // reset while a request is pending
        exp_flush_q.push_back(32'hfffffffc);
        br = 1; tgt = 32'h00000100;
        tick();
        br = 0;
        chk("rr_req", addr, 32'h00000100);
        reset = 1;
        tick();
        chk("rr_busy", {31'd0, busy}, 32'd0);
        chk("rr_pc", pc_f, RST_PC);
`ifdef CPU7_IFU_PCGEN_PERF_EN
        chk("rr_perf_drop", {16'd0, perf_drop}, 32'd0);
`endif
        reset = 0;
        exp_req_q.push_back(32'h1c000000);
        tick();
        chk("rr_req_addr", addr, 32'h1c000000);
        ack_cycle(1'b1);
        tick();

        chk("req_q_empty", exp_req_q.size(), 32'd0);
        chk("flush_q_empty", exp_flush_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
